// File: rtl/iter_divider.sv
// RV32M-style iterative divider: one restoring step per cycle, 33-cycle latency.
// Define DIV_FASTPATH_EN to let divide-by-zero and signed overflow finish in one cycle.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Din1,
  input  logic [WIDTH-1:0] Din2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Dout,
  output logic [1:0]       o_dbg_state
);

  // Handshake: start/op/Din1/Din2 are taken only in IDLE (flush low); done is a
  // one-cycle strobe with Dout valid, and Dout holds until the next done.
  localparam int DW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DW-1:0]    r_acc;
  logic [WIDTH-1:0] r_divisor;
  logic [5:0]       r_cnt;
  logic             r_qsign;
  logic             r_rsign;
  logic             r_div_zero;
  logic             r_rem_sel;

  logic             w_signed;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_sub;
  logic [DW-1:0]    w_step;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_result;

  assign w_signed = ~op[0];
  assign w_a_mag  = (w_signed && Din1[WIDTH-1]) ? -Din1 : Din1;
  assign w_b_mag  = (w_signed && Din2[WIDTH-1]) ? -Din2 : Din2;
  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_last   = (r_cnt == 6'(WIDTH - 1));

`ifdef DIV_FASTPATH_EN
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_res;

  assign w_fast = (Din2 == '0) ||
                  (w_signed && (Din1 == {1'b1, {(WIDTH-1){1'b0}}}) && (Din2 == '1));
  // Overflow quotient equals the dividend (most negative value).
  assign w_fast_res = (Din2 == '0) ? (op[1] ? Din1 : '1) : (op[1] ? '0 : Din1);
`endif

  // Shifted partial remainder carries one extra bit so the compare is exact.
  assign w_rem_sh = r_acc[DW-1:WIDTH-1];
  assign w_sub    = w_rem_sh[WIDTH-1:0] - r_divisor;

  always_comb begin
    w_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    if (w_rem_sh >= {1'b0, r_divisor}) begin
      w_step = {w_sub, r_acc[WIDTH-2:0], 1'b1};
    end
  end

  assign w_q = w_step[WIDTH-1:0];
  assign w_r = w_step[DW-1:WIDTH];

  // A zero divisor keeps the all-ones quotient regardless of operand signs.
  always_comb begin
    w_result = w_q;
    if (r_rem_sel) begin
      w_result = r_rsign ? -w_r : w_r;
    end else if (r_qsign && !r_div_zero) begin
      w_result = -w_q;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef DIV_FASTPATH_EN
          w_next = w_fast ? S_DONE : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_divisor  <= '0;
      r_cnt      <= '0;
      r_qsign    <= 1'b0;
      r_rsign    <= 1'b0;
      r_div_zero <= 1'b0;
      r_rem_sel  <= 1'b0;
      Dout       <= '0;
    end else if (w_accept) begin
      r_acc      <= {{WIDTH{1'b0}}, w_a_mag};
      r_divisor  <= w_b_mag;
      r_cnt      <= '0;
      r_qsign    <= w_signed & (Din1[WIDTH-1] ^ Din2[WIDTH-1]);
      r_rsign    <= w_signed & Din1[WIDTH-1];
      r_div_zero <= (Din2 == '0);
      r_rem_sel  <= op[1];
`ifdef DIV_FASTPATH_EN
      if (w_fast) begin
        Dout <= w_fast_res;
      end
`endif
    end else if ((r_state == S_CALC) && !flush) begin
      r_acc <= w_step;
      r_cnt <= r_cnt + 6'd1;
      if (w_last) begin
        Dout <= w_result;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: RV32M reference model, scoreboard of expected
// results and completion edges, plus literal expectations per vector.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] din1 = '0;
  logic [31:0] din2 = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] dout;
  logic [1:0]  dbg_state;

  int          n_cmp = 0;
  int          n_err = 0;
  int          edge_cnt = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m_dout = '0;
  logic [31:0] exp_q[$];
  int          exp_edge_q[$];
  logic [31:0] mon_e;
  int          mon_t;

  iter_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .Din1       (din1),
    .Din2       (din2),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .Dout       (dout),
    .o_dbg_state(dbg_state)
  );

  // Clock / edge counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference: RV32M divide/remainder semantics in plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] mop, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return mop[1] ? a : 32'hFFFF_FFFF;
    if (!mop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return mop[1] ? 32'h0 : 32'h8000_0000;
    case (mop)
      2'd0:    return 32'(sa / sb);
      2'd1:    return a / b;
      2'd2:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [1:0] mop, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef DIV_FASTPATH_EN
    return (b == 32'h0) || (!mop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`else
    return (mop == 2'd3) && (a == 32'h0) && (b == 32'h0) && 1'b0;
`endif
  endfunction

  // Scoreboard: every negedge, done must match the head of the queue in value and edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_done: done=1 at edge %0d, required done=0", edge_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = exp_edge_q.pop_front();
          chk("dout_model", dout, mon_e);
          chk("done_edge", 32'(edge_cnt), 32'(mon_t));
          m_dout = mon_e;
        end
      end else begin
        if (exp_q.size() != 0 && edge_cnt > exp_edge_q[0]) begin
          n_cmp++;
          n_err++;
          $display("FAIL late_done: no done by edge %0d, required at edge %0d",
                   edge_cnt, exp_edge_q[0]);
          void'(exp_q.pop_front());
          void'(exp_edge_q.pop_front());
        end
        chk("dout_hold", dout, m_dout);
      end
    end
  end

  // Driver tasks: called at posedge+1 with the DUT idle.
  task automatic goto_edge(input int t);
    while (edge_cnt < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_lit);
    int n;
    start = 1'b1;
    op    = o;
    din1  = a;
    din2  = b;
    n     = edge_cnt + 1;
    exp_q.push_back(model(o, a, b));
    exp_edge_q.push_back(is_fast(o, a, b) ? n : n + 32);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < 80 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: %0d results pending, required 0", name, exp_q.size());
      exp_q.delete();
      exp_edge_q.delete();
    end
    chk(name, dout, exp_lit);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic start_raw(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    din1  = a;
    din2  = b;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    m_dout = '0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;

    do_op("divu_100_7",   2'd1, 32'd100,          32'd7,          32'd14);
    do_op("remu_100_7",   2'd3, 32'd100,          32'd7,          32'd2);
    do_op("div_m100_7",   2'd0, 32'hFFFF_FF9C,    32'd7,          32'hFFFF_FFF2);
    do_op("rem_m100_7",   2'd2, 32'hFFFF_FF9C,    32'd7,          32'hFFFF_FFFE);
    do_op("rem_100_m7",   2'd2, 32'd100,          32'hFFFF_FFF9,  32'd2);
    do_op("div_m100_m7",  2'd0, 32'hFFFF_FF9C,    32'hFFFF_FFF9,  32'd14);
    do_op("div_5_0",      2'd0, 32'd5,            32'd0,          32'hFFFF_FFFF);
    do_op("remu_5_0",     2'd3, 32'd5,            32'd0,          32'd5);
    do_op("div_m7_0",     2'd0, 32'hFFFF_FFF9,    32'd0,          32'hFFFF_FFFF);
    do_op("rem_m7_0",     2'd2, 32'hFFFF_FFF9,    32'd0,          32'hFFFF_FFF9);
    do_op("div_ovf",      2'd0, 32'h8000_0000,    32'hFFFF_FFFF,  32'h8000_0000);
    do_op("rem_ovf",      2'd2, 32'h8000_0000,    32'hFFFF_FFFF,  32'd0);
    do_op("divu_big",     2'd1, 32'h8000_0000,    32'hFFFF_FFFF,  32'd0);
    do_op("divu_max_1",   2'd1, 32'hFFFF_FFFF,    32'd1,          32'hFFFF_FFFF);
    do_op("remu_max",     2'd3, 32'hFFFF_FFFF,    32'hFFFF_FFFE,  32'd1);

    // start held through the DONE cycle must not launch a second operation
    start_raw(2'd1, 32'd50, 32'd5);
    n = edge_cnt + 1;
    exp_q.push_back(model(2'd1, 32'd50, 32'd5));
    exp_edge_q.push_back(n + 32);
    @(posedge clk);
    #1;
    start = 1'b0;
    goto_edge(n + 32);
    start_raw(2'd1, 32'd1, 32'd1);
    goto_edge(n + 33);
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("done_cycle_start_dout", dout, 32'd10);
    chk("done_cycle_start_busy", 32'(busy), 32'd0);

    // flush at N+10 aborts; a start at N+5 is ignored
    start_raw(2'd1, 32'd1000, 32'd10);
    n = edge_cnt + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("flush_calc_state", 32'(dbg_state), 32'd1);
    @(posedge clk);
    #1;
    goto_edge(n + 4);
    start_raw(2'd1, 32'd7, 32'd7);
    goto_edge(n + 5);
    start = 1'b0;
    goto_edge(n + 9);
    flush = 1'b1;
    goto_edge(n + 10);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_state", 32'(dbg_state), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_dout_hold", dout, 32'd10);

    // reset at N+20 aborts mid-operation and clears Dout
    start_raw(2'd1, 32'd1000, 32'd3);
    n = edge_cnt + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    goto_edge(n + 19);
    rst = 1'b1;
    goto_edge(n + 20);
    rst    = 1'b0;
    m_dout = '0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_dout", dout, 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    do_op("divu_9_3", 2'd1, 32'd9, 32'd3, 32'd3);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width in bits; only 32 is supported.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M semantics).
REQ-007 Din1  input  32  dividend; sampled with start.
REQ-008 Din2  input  32  divisor; sampled with start.
REQ-009 flush  input  1  abort an in-flight operation (pipeline kill).
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse; Dout valid in that cycle.
REQ-012 Dout  output  32  registered result; holds its value until the next done.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, DONE; IDLE->CALC on start, CALC->DONE after 32 iterations, DONE->IDLE unconditionally.
REQ-014 On start in IDLE the block SHALL latch op, |Din1| and |Din2| (magnitudes for DIV/REM, raw values for DIVU/REMU), plus quotient-sign = Din1[31]^Din2[31] and remainder-sign = Din1[31] for signed ops.
REQ-015 CALC SHALL perform one radix-2 restoring step per cycle on a 64-bit {remainder,quotient} register, driven by a 6-bit iteration counter running 0..31.
REQ-016 The start accept edge SHALL be N; CALC SHALL occupy cycles N+1..N+32; done and valid Dout SHALL be present in cycle N+33 (latency 33).
REQ-017 Final fixup SHALL negate the quotient if quotient-sign is set and negate the remainder if remainder-sign is set; DIV/DIVU SHALL return the quotient and REM/REMU the remainder.
REQ-018 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder Din1, for both signed and unsigned ops.
REQ-019 Signed overflow (Din1=0x80000000, Din2=0xFFFFFFFF) SHALL give DIV 0x80000000 and REM 0.
REQ-020 start while busy SHALL be ignored, with no queuing.
REQ-021 start in the DONE cycle SHALL be ignored; a new op is accepted no earlier than the following IDLE cycle.
REQ-022 flush SHALL force IDLE on the next edge from any state, suppress done, and leave Dout unchanged; flush takes priority over start in the same cycle.
REQ-023 busy SHALL fall in the same cycle that done is high only if the state is DONE; busy is high during DONE.

Reset
REQ-024 When rst is high at a clock edge, the block SHALL enter state IDLE, clear the counter and datapath registers, and drive busy=0, done=0, Dout=0.
REQ-025 rst SHALL override flush and start, and SHALL abort a mid-operation division without asserting done.

Configuration
REQ-026 When DIV_FASTPATH_EN is defined, divide-by-zero and signed-overflow operands SHALL bypass CALC: IDLE->DONE, with done in cycle N+1 and results per REQ-018/019.
REQ-027 When DIV_FASTPATH_EN is undefined, all operands SHALL take 33-cycle latency; REQ-018/019 results SHALL arise from the normal iteration and fixup path.

Verification
REQ-028 DIVU 100/7 -> done at N+33 with Dout=14; REMU 100/7 -> Dout=2.
REQ-029 DIV 0xFFFFFF9C(-100)/7 -> 0xFFFFFFF2(-14); REM -100/7 -> 0xFFFFFFFE(-2); REM 100/0xFFFFFFF9(-7) -> 2.
REQ-030 DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; with DIV_FASTPATH_EN defined, done at N+1, otherwise at N+33.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-032 Flush at N+10 -> IDLE at N+11 with no done and Dout holding its prior value; a second start pulsed at N+5 is ignored.
REQ-033 rst at N+20 -> busy=0 and Dout=0 next cycle, no done; a new DIVU 9/3 afterwards -> 3.
